// File: rtl/spi_master_arbiter_pkg.sv
// Shared definitions for the SPI master arbiter and its round-robin picker.
//   arb_state_t : arbiter FSM encoding (IDLE, LAUNCH, WAIT_DONE, GAP)
//   STATE_W     : width of the exported debug state
//   CS_IDLE     : level of a deselected active-low chip select
//   cnt_width() : $clog2-based width helper, never narrower than one bit
package spi_master_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } arb_state_t;

    localparam int   STATE_W = 2;
    localparam logic CS_IDLE = 1'b1;

    // Width needed to count 0..n-1. A degenerate n still gets a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Purely combinational round-robin picker.
//   request    : per-client request vector
//   last_grant : index of the client served most recently
//   winner     : one-hot winner, all zero when nothing is requested
//   winner_idx : binary index of the winner (0 when nothing is requested)
//   any        : at least one request is present
// The search starts at (last_grant+1) mod N and wraps around.
module spi_rr_picker
    import spi_master_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     request,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = |request;
        cand       = 0;
        cand_idx   = '0;
        // Walk from the farthest candidate to the nearest one so the
        // nearest requester after last_grant overwrites everyone else.
        for (int k = N; k >= 1; k--) begin
            cand     = (int'(last_grant) + k) % N;
            cand_idx = IDX_W'(cand);
            if (request[cand_idx]) begin
                winner           = '0;
                winner[cand_idx] = 1'b1;
                winner_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master between REQUESTERS clients with round-robin grants.
// Ports:
//   IN_CLOCK, IN_RESET            : clock, synchronous active-high reset
//   IN_REQUEST / IN_REQUEST_HOLD  : per-client request and burst-hold
//   IN_REQUEST_DATA               : client i drives [i*PACK_LENGTH +: PACK_LENGTH]
//   OUT_GRANT                     : one-hot current grant (or zero)
//   OUT_DONE                      : one-cycle completion pulse to the granted client
//   OUT_RECEIVE_DATA              : last captured pack, held until the next capture
//   OUT_TIMEOUT                   : one-cycle pulse when the watchdog aborts
//   OUT_SPI_LAUNCH / OUT_SPI_DATA : launch pulse and pack towards the master
//   IN_SPI_RECEIVE_DATA           : pack received by the master
//   IN_SPI_ACTION_DONE            : master completion pulse
//   IN_SPI_CS / OUT_CS            : master CS fanned out to the granted device
//   OUT_STATE                     : debug view of the FSM state
//
// Handshake: a client raises IN_REQUEST with its data and keeps both stable
// until it sees OUT_DONE (or the grant disappears after OUT_TIMEOUT). The
// transaction is committed once granted; lowering IN_REQUEST afterwards only
// prevents a hold burst. Towards the master, OUT_SPI_LAUNCH is a single-cycle
// pulse and exactly one IN_SPI_ACTION_DONE is accepted per launch, and only
// while waiting for it.
module spi_master_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int REQUESTERS   = 4,
    parameter int PACK_LENGTH  = 8,
    parameter int TIMEOUT_CLKS = 256,
    parameter int GAP_CLKS     = 2
) (
    input  logic                              IN_CLOCK,
    input  logic                              IN_RESET,
    input  logic [REQUESTERS-1:0]             IN_REQUEST,
    input  logic [REQUESTERS-1:0]             IN_REQUEST_HOLD,
    input  logic [REQUESTERS*PACK_LENGTH-1:0] IN_REQUEST_DATA,
    output logic [REQUESTERS-1:0]             OUT_GRANT,
    output logic [REQUESTERS-1:0]             OUT_DONE,
    output logic [PACK_LENGTH-1:0]            OUT_RECEIVE_DATA,
    output logic                              OUT_TIMEOUT,
    output logic                              OUT_SPI_LAUNCH,
    output logic [PACK_LENGTH-1:0]            OUT_SPI_DATA,
    input  logic [PACK_LENGTH-1:0]            IN_SPI_RECEIVE_DATA,
    input  logic                              IN_SPI_ACTION_DONE,
    input  logic                              IN_SPI_CS,
    output logic [REQUESTERS-1:0]             OUT_CS,
    output logic [STATE_W-1:0]                OUT_STATE
);

    localparam int IDX_W = cnt_width(REQUESTERS);
    localparam int WD_W  = cnt_width(TIMEOUT_CLKS);
    localparam int GAP_W = cnt_width(GAP_CLKS);

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CLKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REQUESTERS - 1);

    arb_state_t             state;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       last_grant;
    logic [WD_W-1:0]        wd_cnt;
    logic [GAP_W-1:0]       gap_cnt;

    logic [REQUESTERS-1:0]  pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [PACK_LENGTH-1:0] pick_data;
    logic [PACK_LENGTH-1:0] held_data;
    logic                   hold_burst;

    spi_rr_picker #(
        .N     (REQUESTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .request    (IN_REQUEST),
        .last_grant (last_grant),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // Data of the arbitration winner and of the current owner (for bursts).
    always_comb begin
        pick_data = '0;
        held_data = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (pick_idx == IDX_W'(i))
                pick_data = IN_REQUEST_DATA[i*PACK_LENGTH +: PACK_LENGTH];
            if (grant_idx == IDX_W'(i))
                held_data = IN_REQUEST_DATA[i*PACK_LENGTH +: PACK_LENGTH];
        end
    end

    // OUT_GRANT is one-hot, so this reduces to hold && request of the owner.
    assign hold_burst = |(OUT_GRANT & IN_REQUEST_HOLD & IN_REQUEST);

    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            state            <= ST_IDLE;
            grant_idx        <= '0;
            last_grant       <= IDX_LAST;
            wd_cnt           <= '0;
            gap_cnt          <= '0;
            OUT_GRANT        <= '0;
            OUT_DONE         <= '0;
            OUT_TIMEOUT      <= 1'b0;
            OUT_SPI_LAUNCH   <= 1'b0;
            OUT_SPI_DATA     <= '0;
            OUT_RECEIVE_DATA <= '0;
        end else begin
            OUT_DONE       <= '0;
            OUT_TIMEOUT    <= 1'b0;
            OUT_SPI_LAUNCH <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state          <= ST_LAUNCH;
                        OUT_GRANT      <= pick_onehot;
                        grant_idx      <= pick_idx;
                        OUT_SPI_DATA   <= pick_data;
                        OUT_SPI_LAUNCH <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    state  <= ST_WAIT_DONE;
                    wd_cnt <= '0;
                end
                ST_WAIT_DONE: begin
                    // Completion takes priority over the watchdog's last cycle.
                    if (IN_SPI_ACTION_DONE) begin
                        OUT_RECEIVE_DATA <= IN_SPI_RECEIVE_DATA;
                        OUT_DONE         <= OUT_GRANT;
                        if (hold_burst) begin
                            // Keep the grant and the pointer; relaunch immediately.
                            state          <= ST_LAUNCH;
                            OUT_SPI_DATA   <= held_data;
                            OUT_SPI_LAUNCH <= 1'b1;
                        end else begin
                            state      <= ST_GAP;
                            gap_cnt    <= '0;
                            OUT_GRANT  <= '0;
                            last_grant <= grant_idx;
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        OUT_TIMEOUT <= 1'b1;
                        state       <= ST_GAP;
                        gap_cnt     <= '0;
                        OUT_GRANT   <= '0;
                        last_grant  <= grant_idx;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Only the granted device follows the master CS; all others stay deselected.
    always_comb begin
        for (int i = 0; i < REQUESTERS; i++)
            OUT_CS[i] = OUT_GRANT[i] ? IN_SPI_CS : CS_IDLE;
    end

    assign OUT_STATE = state;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: directed scenarios plus a randomized phase.
// A behavioural master stub answers launches; a timeline reference model
// predicts every output each cycle from the arbitration rules.
module tb_spi_master_arbiter;
    import spi_master_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int PL  = 8;
    localparam int TO  = 256;
    localparam int GAP = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req, hold;
    logic [N*PL-1:0]   data;
    logic [N-1:0]      grant, done, cs;
    logic [PL-1:0]     rx, spi_data, spi_rx;
    logic              timeout, launch, spi_done, spi_cs;
    logic [STATE_W-1:0] dbg_state;

    spi_master_arbiter #(
        .REQUESTERS   (N),
        .PACK_LENGTH  (PL),
        .TIMEOUT_CLKS (TO),
        .GAP_CLKS     (GAP)
    ) dut (
        .IN_CLOCK            (clk),
        .IN_RESET            (rst),
        .IN_REQUEST          (req),
        .IN_REQUEST_HOLD     (hold),
        .IN_REQUEST_DATA     (data),
        .OUT_GRANT           (grant),
        .OUT_DONE            (done),
        .OUT_RECEIVE_DATA    (rx),
        .OUT_TIMEOUT         (timeout),
        .OUT_SPI_LAUNCH      (launch),
        .OUT_SPI_DATA        (spi_data),
        .IN_SPI_RECEIVE_DATA (spi_rx),
        .IN_SPI_ACTION_DONE  (spi_done),
        .IN_SPI_CS           (spi_cs),
        .OUT_CS              (cs),
        .OUT_STATE           (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_owner = -1;
    int            m_last  = N - 1;
    int            m_free_at = 0;
    int            m_launch_edge = 0;
    logic [PL-1:0] m_tx = '0, m_rx = '0;
    logic [N-1:0]  m_done_vec = '0;
    logic          m_timeout = 1'b0, m_launch = 1'b0;
    logic [PL-1:0] exp_q[$];

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic release_grant();
        m_last    = m_owner;
        m_owner   = -1;
        m_free_at = cyc + GAP + 1;   // GAP idle cycles, then one IDLE cycle
    endtask

    // Applies the inputs sampled at the edge that just occurred.
    task automatic model_edge();
        int o;
        m_done_vec = '0;
        m_timeout  = 1'b0;
        m_launch   = 1'b0;
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_free_at = cyc + 1;
            m_tx = '0; m_rx = '0; exp_q.delete();
        end else if (m_owner < 0) begin
            if (cyc >= m_free_at && req != '0) begin
                o = rr_pick(m_last, req);
                m_owner = o; m_tx = data[o*PL +: PL];
                m_launch = 1'b1; m_launch_edge = cyc;
            end
        end else if (cyc >= m_launch_edge + 2) begin
            if (spi_done) begin
                m_done_vec[m_owner] = 1'b1;
                m_rx = spi_rx;
                exp_q.push_back(spi_rx);
                if (hold[m_owner] && req[m_owner]) begin
                    m_tx = data[m_owner*PL +: PL];
                    m_launch = 1'b1; m_launch_edge = cyc;
                end else begin
                    release_grant();
                end
            end else if (cyc == m_launch_edge + 1 + TO) begin
                m_timeout = 1'b1;
                release_grant();
            end
        end
    endtask

    // ---------------- master stub / client drivers ----------------
    int            stub_cnt = 0, stub_dmin = 3, stub_dmax = 3, stub_force = 0;
    int            stub_sup_rate = 0, stray_rate = 0;
    logic          stub_suppress = 1'b0, stray_now = 1'b0, auto_en = 1'b0;
    logic [PL-1:0] stub_last_rx = '0;

    task automatic stub_drive();
        spi_done = 1'b0;
        if (rst) begin
            stub_cnt = 0; spi_cs = 1'b1;
        end else if (launch) begin
            if (stub_suppress || $urandom_range(0, 99) < stub_sup_rate) stub_cnt = 0;
            else if (stub_force > 0) stub_cnt = stub_force;
            else stub_cnt = $urandom_range(stub_dmin, stub_dmax);
            spi_cs = 1'b0;
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                spi_done = 1'b1; spi_rx = PL'($urandom); stub_last_rx = spi_rx; spi_cs = 1'b1;
            end
        end else if (timeout) begin
            spi_cs = 1'b1;
        end else if (grant == '0 && (stray_now || (stray_rate > 0 && $urandom_range(0, 99) < stray_rate))) begin
            spi_done = 1'b1; spi_rx = PL'($urandom); stray_now = 1'b0;
        end
    endtask

    task automatic client_auto();
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                req[i]  = 1'($urandom_range(0, 1));
                hold[i] = ($urandom_range(0, 2) == 0);
                data[i*PL +: PL] = PL'($urandom);
            end else if (grant[i] && $urandom_range(0, 15) == 0) begin
                req[i] = 1'b0;
            end else if (!req[i] && !grant[i] && $urandom_range(0, 5) == 0) begin
                req[i]  = 1'b1;
                hold[i] = ($urandom_range(0, 2) == 0);
                data[i*PL +: PL] = PL'($urandom);
            end
        end
    endtask

    // Grant-order and gap bookkeeping from observed outputs.
    int           obs_order[$];
    int           gap_q[$];
    int           zero_run = 0;
    logic [N-1:0] prev_grant = '0;

    task automatic step();
        logic [N-1:0] exp_grant, exp_cs;
        @(negedge clk);
        cyc++;
        model_edge();
        exp_grant = '0;
        for (int i = 0; i < N; i++) begin
            exp_grant[i] = (m_owner == i);
            exp_cs[i]    = (m_owner == i) ? spi_cs : 1'b1;
        end
        check_eq("grant", grant, exp_grant);
        check_eq("done", done, m_done_vec);
        check_eq("timeout", timeout, m_timeout);
        check_eq("launch", launch, m_launch);
        check_eq("spi_data", spi_data, m_tx);
        check_eq("rx_data", rx, m_rx);
        check_eq("cs", cs, exp_cs);
        if (done != '0) begin
            if (exp_q.size() == 0) check_eq("rx_unexpected_done", done, '0);
            else check_eq("rx_scoreboard", rx, exp_q.pop_front());
        end
        if (grant == '0) zero_run++;
        else if (prev_grant == '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) obs_order.push_back(i);
            gap_q.push_back(zero_run);
            zero_run = 0;
        end
        prev_grant = grant;
        stub_drive();
        if (auto_en) client_auto();
    endtask

    // ---------------- scenarios ----------------
    logic [PL-1:0] burst_vals[3];
    int            n, lc, burst_idx, done3_cnt;

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; req = '0; hold = '0; data = '0;
        spi_done = 1'b0; spi_rx = '0; spi_cs = 1'b1;
        burst_vals[0] = 8'h11; burst_vals[1] = 8'h22; burst_vals[2] = 8'h33;

        // Reset values
        repeat (3) step();
        check_eq("rst_grant", grant, '0);
        check_eq("rst_cs", cs, 4'hF);
        check_eq("rst_spi_data", spi_data, '0);
        check_eq("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;

        // Single request from client 2
        req[2] = 1'b1; data[2*PL +: PL] = 8'hEA;
        n = 0; while (launch !== 1'b1 && n < 20) begin step(); n++; end
        check_eq("single_launch_seen", launch, 1);
        check_eq("single_grant", grant, 4'b0100);
        check_eq("single_spi_data", spi_data, 8'hEA);
        step();
        check_eq("single_cs", cs, 4'b1011);
        n = 0; while (done[2] !== 1'b1 && n < 30) begin step(); n++; end
        check_eq("single_done", done, 4'b0100);
        check_eq("single_rx", rx, stub_last_rx);
        req[2] = 1'b0;
        repeat (GAP + 3) step();

        // Fairness from reset: all four request continuously
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < N; i++) data[i*PL +: PL] = PL'($urandom);
        req = '1; obs_order.delete(); gap_q.delete(); zero_run = 0;
        n = 0; while (obs_order.size() < 5 && n < 200) begin step(); n++; end
        check_eq("fair_grants_seen", obs_order.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < obs_order.size()) check_eq("fair_order", obs_order[k], k % N);
            if (k >= 1 && k < gap_q.size()) check_eq("fair_gap", gap_q[k], GAP + 1);
        end
        req = '0;
        repeat (20) step();

        // Hold burst from client 1 while client 0 waits
        req[1] = 1'b1; hold[1] = 1'b1; data[1*PL +: PL] = burst_vals[0]; burst_idx = 0;
        n = 0;
        while (grant[0] !== 1'b1 && n < 100) begin
            step(); n++;
            if (launch && grant[1]) begin
                if (burst_idx < 3) check_eq("burst_data", spi_data, burst_vals[burst_idx]);
                burst_idx++;
                if (burst_idx < 3) data[1*PL +: PL] = burst_vals[burst_idx];
                if (burst_idx == 1) begin req[0] = 1'b1; data[0 +: PL] = 8'h5C; end
                if (burst_idx == 3) hold[1] = 1'b0;
            end
            if (done[1] && burst_idx >= 3) req[1] = 1'b0;
        end
        check_eq("burst_launches", burst_idx, 3);
        check_eq("burst_then_c0", grant, 4'b0001);
        n = 0; while (done[0] !== 1'b1 && n < 30) begin step(); n++; end
        check_eq("burst_c0_done", done, 4'b0001);
        req[0] = 1'b0;
        repeat (GAP + 3) step();

        // Watchdog timeout on client 3, client 0 served afterwards
        stub_suppress = 1'b1; req[3] = 1'b1; data[3*PL +: PL] = 8'h3C;
        n = 0; while (launch !== 1'b1 && n < 20) begin step(); n++; end
        lc = cyc; req[0] = 1'b1; done3_cnt = 0;
        n = 0;
        while (timeout !== 1'b1 && n < TO + 20) begin
            step(); n++;
            if (done != '0) done3_cnt++;
        end
        check_eq("to_seen", timeout, 1);
        check_eq("to_latency", cyc - (lc + 1), TO);
        check_eq("to_no_done", done3_cnt, 0);
        req[3] = 1'b0; stub_suppress = 1'b0;
        n = 0; while (done[0] !== 1'b1 && n < 40) begin step(); n++; end
        check_eq("to_next_served", done, 4'b0001);
        req[0] = 1'b0;
        repeat (GAP + 3) step();

        // Done on the final watchdog cycle
        stub_force = TO; req[1] = 1'b1; data[1*PL +: PL] = 8'hA5;
        n = 0; while (launch !== 1'b1 && n < 20) begin step(); n++; end
        lc = cyc;
        n = 0; while (done == '0 && timeout !== 1'b1 && n < TO + 20) begin step(); n++; end
        check_eq("coin_done", done, 4'b0010);
        check_eq("coin_timeout", timeout, 0);
        check_eq("coin_latency", cyc - (lc + 1), TO);
        stub_force = 0; req[1] = 1'b0;
        repeat (GAP + 3) step();

        // Reset pulsed during WAIT_DONE
        stub_suppress = 1'b1; req[2] = 1'b1; data[2*PL +: PL] = 8'hC3;
        n = 0; while (launch !== 1'b1 && n < 20) begin step(); n++; end
        repeat (3) step();
        rst = 1'b1; step();
        check_eq("mid_rst_grant", grant, '0);
        check_eq("mid_rst_launch", launch, 0);
        check_eq("mid_rst_spi_data", spi_data, '0);
        check_eq("mid_rst_rx", rx, '0);
        check_eq("mid_rst_cs", cs, 4'hF);
        rst = 1'b0; req[2] = 1'b0; stub_suppress = 1'b0;
        repeat (5) step();

        // Stray done while idle
        stray_now = 1'b1; step(); step();
        check_eq("stray_done", done, '0);
        check_eq("stray_rx", rx, '0);
        repeat (3) step();

        // Randomized traffic
        stub_dmin = 1; stub_dmax = 8; stub_sup_rate = 3; stray_rate = 3; auto_en = 1'b1;
        repeat (3000) step();
        auto_en = 1'b0; req = '0; hold = '0; stub_sup_rate = 0; stray_rate = 0;
        repeat (TO + 20) step();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
